readout_rr_sched: RTL

Event-level controller for the 12-memory readout merge. It sequences one event per new_event pulse and latches item counts and BX. It generates per-memory read addresses and arbitrates round-robin among memories that still hold data, which replaces fixed priority. It issues the mux select plus a valid strobe aligned to 1-cycle-latency memory data, and flags done/truncation against a per-event cycle budget.

---
 rtl/readout_rr_sched.sv | 127 ++++++++++++
 1 files changed

// File: rtl/readout_rr_sched.sv
// Event sequencer for the multi-memory readout merge: round-robin grants among memories with data left.
// Grant to valid latency is 1 cycle; new_event restarts the event at any time and reset overrides it.
module readout_rr_sched #(
  parameter int NMEM         = 12,
  parameter int AW           = 6,
  parameter int SETUP_CYCLES = 2,
  parameter int MAX_CYCLES   = 100
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                new_event,
  input  logic [2:0]          BX,
  input  logic [NMEM*AW-1:0]  number_in,
  output logic [NMEM*AW-1:0]  read_add,
  output logic [3:0]          sel,
  output logic                valid,
  output logic [2:0]          bx_out,
  output logic                done,
  output logic                truncated,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, SETUP, READ, DONE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] cnt  [NMEM];
  logic [AW-1:0] addr [NMEM];
  logic [3:0]    ptr;
  logic [6:0]    cyc;
  logic [1:0]    hold;
  logic [NMEM-1:0] has_dat;
  logic          gnt_vld;
  logic [3:0]    gnt;
  logic [3:0]    ptr_nxt;
  logic [4:0]    idx;
  logic          last_cyc;

  always_comb begin
    for (int i = 0; i < NMEM; i++) has_dat[i] = (addr[i] != cnt[i]);
  end

  assign last_cyc = (cyc == 7'(MAX_CYCLES - 1));

  // First memory with data, scanning upward from ptr with wraparound.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    idx     = '0;
    for (int k = 0; k < NMEM; k++) begin
      idx = {1'b0, ptr} + 5'(k);
      if (idx >= 5'(NMEM)) idx = idx - 5'(NMEM);
      if (!gnt_vld && state == READ && has_dat[idx[3:0]]) begin
        gnt_vld = 1'b1;
        gnt     = idx[3:0];
      end
    end
    ptr_nxt = (gnt == 4'(NMEM - 1)) ? 4'd0 : gnt + 4'd1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = IDLE;
      SETUP: if (hold == 2'd0) state_nxt = READ;
      READ:  if (!(|has_dat) || last_cyc) state_nxt = DONE;
      DONE:  state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (new_event) state_nxt = SETUP;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= '0;
      cyc       <= '0;
      hold      <= '0;
      sel       <= '0;
      valid     <= 1'b0;
      bx_out    <= '0;
      done      <= 1'b1;
      truncated <= 1'b0;
      for (int i = 0; i < NMEM; i++) begin
        cnt[i]  <= '0;
        addr[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (new_event) begin
        // Any grant computed this cycle is dropped with the old event.
        for (int i = 0; i < NMEM; i++) begin
          cnt[i]  <= number_in[i*AW +: AW];
          addr[i] <= '0;
        end
        bx_out    <= BX;
        ptr       <= '0;
        cyc       <= '0;
        hold      <= 2'(SETUP_CYCLES - 1);
        truncated <= 1'b0;
        done      <= 1'b0;
        valid     <= 1'b0;
      end else begin
        valid <= gnt_vld;
        if (gnt_vld) begin
          sel        <= gnt;
          addr[gnt]  <= addr[gnt] + 1'b1;
          ptr        <= ptr_nxt;
        end
        if (state == SETUP) hold <= hold - 2'd1;
        if (state == READ) begin
          cyc <= cyc + 7'd1;
          if (state_nxt == DONE) begin
            done      <= 1'b1;
            truncated <= (|has_dat) && last_cyc;
          end
        end
      end
    end
  end

  for (genvar i = 0; i < NMEM; i++) begin : g_ra
    assign read_add[i*AW +: AW] = addr[i];
  end

  assign busy = (state == SETUP) || (state == READ);

endmodule
